// File: rtl/dn_benes_ctrl_pkg.sv
// Shared definitions for the Benes distribution-network controller:
// the FSM state encoding and the level count as a function of port count.
package dn_benes_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SET   = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  // A Benes network on n ports has 2*log2(n)-1 switch levels.
  function automatic int unsigned n_levels(input int unsigned n);
    return 2 * $clog2(n) - 1;
  endfunction

endpackage

// File: rtl/dn_valid_pipe.sv
// Fixed-depth 1-bit valid tracker with synchronous clear.
// It follows data through a pipelined network so that "output valid" matches the data latency.
module dn_valid_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk_i,
  input  logic clear_i,
  input  logic valid_i,
  output logic valid_o,
  output logic busy_o
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  // Shift toward the output end; stage 0 takes the new valid.
  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = valid_i;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  // State register; clear drops every beat in flight.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign valid_o = sr_q[DEPTH-1];
  assign busy_o  = |sr_q;

endmodule

// File: rtl/dn_benes_ctrl.sv
// Sequencing controller for dn_benes. It loads the per-level route words, pulses set_en,
// then gates route_en for the commanded number of beats and drains before signalling done.
module dn_benes_ctrl
  import dn_benes_ctrl_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned N_LEVELS = n_levels(N),
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned PIPE_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [LEN_W-1:0]        cmd_len,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [N-1:0]            cfg_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    set_en,
  output logic                    route_en,
  output logic [N_LEVELS*N-1:0]   route_signals,
  output logic                    out_valid,
  output logic                    done
);

  localparam int unsigned LVL_W  = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1;
  localparam int unsigned DCNT_W = $clog2(PIPE_LAT + 1);
  localparam logic [LVL_W-1:0]  LAST_LVL   = LVL_W'(N_LEVELS - 1);
  localparam logic [DCNT_W-1:0] DRAIN_INIT = DCNT_W'(PIPE_LAT);

  state_e                  state_q, state_d;
  logic [LVL_W-1:0]        lvl_q, lvl_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [DCNT_W-1:0]       drain_q, drain_d;
  logic [N_LEVELS*N-1:0]   route_q, route_d;
  logic                    pipe_busy;

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    lvl_d     = lvl_q;
    len_d     = len_q;
    drain_d   = drain_q;
    route_d   = route_q;
    cmd_ready = 1'b0;
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    set_en    = 1'b0;
    route_en  = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          len_d   = cmd_len;
          lvl_d   = '0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          route_d[lvl_q*N +: N] = cfg_data;
          lvl_d                 = lvl_q + LVL_W'(1);
          state_d               = (lvl_q == LAST_LVL) ? ST_SET : ST_LOAD;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_SET: begin
        set_en  = 1'b1;
        drain_d = DRAIN_INIT;
        state_d = (len_q != '0) ? ST_RUN : ST_DRAIN;
      end
      ST_RUN: begin
        in_ready = 1'b1;
        route_en = in_valid;
        if (in_valid) begin
          len_d = len_q - LEN_W'(1);
          if (len_q == LEN_W'(1)) begin
            drain_d = DRAIN_INIT;
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // The countdown gives a fixed PIPE_LAT wait even when nothing was routed.
        if ((drain_q == '0) && !pipe_busy) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (drain_q != '0) begin
          drain_d = drain_q - DCNT_W'(1);
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lvl_q   <= '0;
      len_q   <= '0;
      drain_q <= '0;
      route_q <= '0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      len_q   <= len_d;
      drain_q <= drain_d;
      route_q <= route_d;
    end
  end

  assign route_signals = route_q;

  dn_valid_pipe #(
    .DEPTH (PIPE_LAT)
  ) u_valid_pipe (
    .clk_i   (clk),
    .clear_i (reset),
    .valid_i (route_en),
    .valid_o (out_valid),
    .busy_o  (pipe_busy)
  );

endmodule

// File: tb/tb_dn_benes_ctrl.sv
// Directed bench for dn_benes_ctrl: a phase-level reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_dn_benes_ctrl;
  localparam int N     = 8;
  localparam int NL    = 5;
  localparam int LEN_W = 16;
  localparam int PL    = 1;

  localparam int P_IDLE = 0, P_CFG = 1, P_PROG = 2, P_DATA = 3, P_FLUSH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              cfg_valid = 1'b0;
  logic [N-1:0]      cfg_data = '0;
  logic              in_valid = 1'b0;
  logic              cmd_ready, cfg_ready, in_ready, set_en, route_en, out_valid, done;
  logic [NL*N-1:0]   route_signals;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dn_benes_ctrl #(.N(N), .N_LEVELS(NL), .LEN_W(LEN_W), .PIPE_LAT(PL)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .set_en(set_en), .route_en(route_en), .route_signals(route_signals),
    .out_valid(out_valid), .done(done)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model state: what phase the command is in, how much work is left.
  int           ph = P_IDLE;
  int           m_lv = 0, m_wait = 0, m_beats = 0;
  logic [N-1:0] m_words [NL];
  logic         m_hist [PL];
  bit           m_live = 1'b0;

  // Observation counters for the literal checks.
  int cyc = 0, n_set = 0, n_route = 0, n_out = 0, n_done = 0;
  int last_route_cyc = 0, last_out_cyc = 0, last_set_cyc = 0, last_done_cyc = 0;

  always @(negedge clk) begin : model_cmp
    logic [NL*N-1:0] e_rs;
    logic            e_route;
    cyc++;
    if (set_en === 1'b1)    begin n_set++;   last_set_cyc   = cyc; end
    if (route_en === 1'b1)  begin n_route++; last_route_cyc = cyc; end
    if (out_valid === 1'b1) begin n_out++;   last_out_cyc   = cyc; end
    if (done === 1'b1)      begin n_done++;  last_done_cyc  = cyc; end

    e_route = (ph == P_DATA) && in_valid;
    for (int k = 0; k < NL; k++) e_rs[k*N +: N] = m_words[k];

    if (m_live) begin
      chk("cmd_ready", cmd_ready, ph == P_IDLE);
      chk("cfg_ready", cfg_ready, ph == P_CFG);
      chk("in_ready",  in_ready,  ph == P_DATA);
      chk("set_en",    set_en,    ph == P_PROG);
      chk("route_en",  route_en,  e_route);
      chk("out_valid", out_valid, m_hist[PL-1]);
      chk("done",      done,      (ph == P_FLUSH) && (m_wait == 0));
      chk("route_signals", route_signals, e_rs);
      chk("set_route_excl", set_en & route_en, 1'b0);
    end

    for (int k = PL - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = e_route;

    if (reset) begin
      ph = P_IDLE;
      for (int k = 0; k < NL; k++) m_words[k] = '0;
      for (int k = 0; k < PL; k++) m_hist[k] = 1'b0;
      m_live = 1'b1;
    end else begin
      case (ph)
        P_IDLE: if (cmd_valid) begin m_beats = cmd_len; m_lv = 0; ph = P_CFG; end
        P_CFG: if (cfg_valid) begin
          m_words[m_lv] = cfg_data;
          m_lv++;
          if (m_lv == NL) ph = P_PROG;
        end
        P_PROG: begin m_wait = PL; ph = (m_beats != 0) ? P_DATA : P_FLUSH; end
        P_DATA: if (in_valid) begin
          m_beats--;
          if (m_beats == 0) begin m_wait = PL; ph = P_FLUSH; end
        end
        P_FLUSH: if (m_wait == 0) ph = P_IDLE; else m_wait--;
        default: ph = P_IDLE;
      endcase
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int len);
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic load(input logic [NL*N-1:0] w, input bit gaps);
    for (int i = 0; i < NL; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = w[i*N +: N];
      step(1);
      if (gaps) begin
        cfg_valid = 1'b0;
        cfg_data  = 8'hEE;
        step(1);
      end
    end
    cfg_valid = 1'b0;
  endtask

  // Returns in the cycle after done, or records a failure when the budget runs out.
  task automatic wait_done(input int limit);
    int d0;
    d0 = n_done;
    for (int i = 0; i < limit; i++) begin
      step(1);
      if (n_done > d0) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got no done within %0d cycles, required a done pulse", limit);
  endtask

  initial begin
    int s0, r0, o0, d0;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    chk("lit_reset_cmd_ready", cmd_ready, 1'b1);
    chk("lit_reset_rs", route_signals, 40'h0);

    // Basic: 4 continuous beats.
    issue(4);
    load(40'h1008040201, 1'b0);
    chk("lit_s1_rs", route_signals, 40'h1008040201);
    chk("lit_s1_set_en", set_en, 1'b1);
    s0 = n_set; r0 = n_route; o0 = n_out;
    step(1);
    in_valid = 1'b1;
    step(4);
    in_valid = 1'b0;
    wait_done(20);
    chk("lit_s1_set_pulses", n_set - s0, 1);
    chk("lit_s1_route_cnt", n_route - r0, 4);
    chk("lit_s1_out_cnt", n_out - o0, 4);
    chk("lit_s1_out_lag", last_out_cyc - last_route_cyc, 1);
    chk("lit_s1_done_gap", last_done_cyc - last_route_cyc, 2);
    chk("lit_s1_idle_after", cmd_ready, 1'b1);

    // Bubbles in the data stream.
    issue(3);
    load(40'h1514131211, 1'b0);
    step(1);
    r0 = n_route;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      step(1);
    end
    in_valid = 1'b0;
    wait_done(20);
    chk("lit_s2_route_cnt", n_route - r0, 3);
    chk("lit_s2_done_gap", last_done_cyc - last_route_cyc, 2);

    // Zero-length command.
    issue(0);
    load(40'h0F0E0D0C0B, 1'b0);
    r0 = n_route; o0 = n_out;
    wait_done(20);
    chk("lit_s3_route_cnt", n_route - r0, 0);
    chk("lit_s3_out_cnt", n_out - o0, 0);
    chk("lit_s3_done_gap", last_done_cyc - last_set_cyc, 2);

    // Ignored inputs and gapped cfg beats.
    cfg_valid = 1'b1;
    cfg_data  = 8'hFF;
    step(2);
    cfg_valid = 1'b0;
    chk("lit_s4_cfg_ignored", route_signals, 40'h0F0E0D0C0B);
    issue(2);
    load(40'h2524232221, 1'b1);
    chk("lit_s4_rs", route_signals, 40'h2524232221);
    step(1);
    r0 = n_route;
    cmd_valid = 1'b1;
    cmd_len   = 16'd7;
    chk("lit_s4_cmd_ready_run", cmd_ready, 1'b0);
    in_valid = 1'b1;
    step(2);
    in_valid  = 1'b0;
    cmd_valid = 1'b0;
    wait_done(20);
    chk("lit_s4_route_cnt", n_route - r0, 2);

    // Reset in the middle of RUN.
    issue(5);
    load(40'h3534333231, 1'b0);
    step(1);
    in_valid = 1'b1;
    step(2);
    reset = 1'b1;
    d0 = n_done;
    step(1);
    chk("lit_s5_cmd_ready", cmd_ready, 1'b1);
    chk("lit_s5_route_en", route_en, 1'b0);
    chk("lit_s5_out_valid", out_valid, 1'b0);
    chk("lit_s5_rs", route_signals, 40'h0);
    reset = 1'b0;
    in_valid = 1'b0;
    step(8);
    chk("lit_s5_no_done", n_done - d0, 0);

    // Back-to-back commands.
    issue(1);
    load(40'h4544434241, 1'b0);
    step(1);
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    wait_done(20);
    chk("lit_s6_cmd_ready", cmd_ready, 1'b1);
    issue(2);
    load(40'hA5A4A3A2A1, 1'b0);
    chk("lit_s6_rs", route_signals, 40'hA5A4A3A2A1);
    step(1);
    in_valid = 1'b1;
    step(2);
    in_valid = 1'b0;
    wait_done(20);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
